// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester, arbiter and RAM-side signals for the shared data RAM.
// slave is the arbiter's view; master is the requester/RAM environment's view.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0]            lock;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wrdata0;
  logic [DATA_WIDTH-1:0] wrdata1;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wrdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req, we, lock, addr0, addr1, wrdata0, wrdata1, ram_rdata,
    output gnt, rvalid, rdata, ram_we, ram_addr, ram_wrdata
  );

  modport master (
    output req, we, lock, addr0, addr1, wrdata0, wrdata1, ram_rdata,
    input  gnt, rvalid, rdata, ram_we, ram_addr, ram_wrdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter with per-port lock in front of a single-port
// synchronous data RAM; routes 1-cycle-latency read data back to the winner.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  rr_ptr;
  logic                  rr_ptr_next;
  logic [1:0]            gnt;
  logic [1:0]            rvalid_q;
  logic                  mux_we;
  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0] mux_wrdata;

  // rvalid_q doubles as the owner tag of the read currently in the RAM pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      rvalid_q <= gnt & ~bus.we;
    end
  end

  always_comb begin
    gnt         = 2'b00;
    state_next  = state;
    rr_ptr_next = rr_ptr;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.req == 2'b11) begin
            gnt = rr_ptr ? 2'b10 : 2'b01;
          end else begin
            gnt = bus.req;
          end
          if (gnt[0]) begin
            rr_ptr_next = 1'b1;
            if (bus.lock[0]) begin
              state_next = LOCK0;
            end
          end else if (gnt[1]) begin
            rr_ptr_next = 1'b0;
            if (bus.lock[1]) begin
              state_next = LOCK1;
            end
          end
        end
        // A locked owner keeps the RAM even while idle; the lock bit alone ends it.
        LOCK0: begin
          gnt = {1'b0, bus.req[0]};
          if (!bus.lock[0]) begin
            state_next  = IDLE;
            rr_ptr_next = 1'b1;
          end
        end
        LOCK1: begin
          gnt = {bus.req[1], 1'b0};
          if (!bus.lock[1]) begin
            state_next  = IDLE;
            rr_ptr_next = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mux_addr   = bus.addr0;
    mux_wrdata = bus.wrdata0;
    mux_we     = gnt[0] & bus.we[0];
    if (gnt[1]) begin
      mux_addr   = bus.addr1;
      mux_wrdata = bus.wrdata1;
      mux_we     = bus.we[1];
    end
  end

  assign bus.gnt        = gnt;
  assign bus.ram_we     = mux_we;
  assign bus.ram_addr   = mux_addr;
  assign bus.ram_wrdata = mux_wrdata;
  assign bus.rvalid     = rst ? 2'b00 : rvalid_q;
  assign bus.rdata      = bus.ram_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized run, all
// checked against a behavioural arbitration/memory model kept in the bench.
module tb_data_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment RAM (registered read, read-before-write) and the model's view of it.
  logic [DW-1:0] ram    [0:1023];
  logic [DW-1:0] shadow [0:1023];

  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wrdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;

  int m_owner = -1;
  int m_fav   = 0;

  logic [1:0]    exp_gnt, obs_gnt, exp_rvalid, obs_rvalid;
  logic          exp_ram_we, obs_ram_we;
  logic [AW-1:0] exp_ram_addr, obs_ram_addr;
  logic [DW-1:0] exp_ram_wrdata, obs_ram_wrdata, exp_rdata, obs_rdata;

  task automatic apply_stimulus(input logic r, input logic [1:0] rq, input logic [1:0] wen,
                                input logic [1:0] lk, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1);
    int g;
    rst         = r;
    bus.req     = rq;
    bus.we      = wen;
    bus.lock    = lk;
    bus.addr0   = a0;
    bus.addr1   = a1;
    bus.wrdata0 = d0;
    bus.wrdata1 = d1;
    g = -1;
    if (r) begin
      m_owner = -1;
      m_fav   = 0;
    end else if (m_owner >= 0) begin
      if (rq[m_owner]) g = m_owner;
      if (!lk[m_owner]) begin
        m_fav   = 1 - m_owner;
        m_owner = -1;
      end
    end else begin
      if (rq == 2'b11) g = m_fav;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      if (g >= 0) begin
        m_fav = 1 - g;
        if (lk[g]) m_owner = g;
      end
    end
    exp_gnt        = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    exp_ram_addr   = (g == 1) ? a1 : a0;
    exp_ram_wrdata = (g == 1) ? d1 : d0;
    exp_ram_we     = 1'b0;
    exp_rvalid     = 2'b00;
    exp_rdata      = '0;
    if (g >= 0) begin
      if (wen[g]) begin
        exp_ram_we           = 1'b1;
        shadow[exp_ram_addr] = exp_ram_wrdata;
      end else begin
        exp_rvalid = exp_gnt;
        exp_rdata  = shadow[exp_ram_addr];
      end
    end
    @(negedge clk);
    obs_gnt        = bus.gnt;
    obs_ram_we     = bus.ram_we;
    obs_ram_addr   = bus.ram_addr;
    obs_ram_wrdata = bus.ram_wrdata;
    @(posedge clk);
    #1;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
  endtask

  task automatic test_reset();
    apply_stimulus(1'b1, 2'b11, 2'b11, 2'b00, 10'h001, 10'h002, 32'h1, 32'h2);
    total++; if (obs_gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 00", obs_gnt); end
    total++; if (obs_ram_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_ram_we: got %b want 0", obs_ram_we); end
    total++; if (obs_rvalid !== 2'b00) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 00", obs_rvalid); end
  endtask

  task automatic test_single_read();
    ram[10'h010]    = 32'hDEADBEEF;
    shadow[10'h010] = 32'hDEADBEEF;
    apply_stimulus(1'b0, 2'b01, 2'b00, 2'b00, 10'h010, 10'h000, 32'h0, 32'h0);
    total++; if (obs_gnt !== 2'b01) begin bad++; $display("[TB] FAIL single_gnt: got %b want 01", obs_gnt); end
    total++; if (obs_ram_addr !== 10'h010) begin bad++; $display("[TB] FAIL single_addr: got %h want 010", obs_ram_addr); end
    total++; if (obs_rvalid !== 2'b01) begin bad++; $display("[TB] FAIL single_rvalid: got %b want 01", obs_rvalid); end
    total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_rdata: got %h want deadbeef", obs_rdata); end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    apply_stimulus(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      apply_stimulus(1'b0, 2'b11, 2'b00, 2'b00, AW'($urandom_range(0, 1023)),
                     AW'($urandom_range(0, 1023)), DW'($urandom), DW'($urandom));
      total++; if (obs_gnt !== want) begin bad++; $display("[TB] FAIL contention_gnt[%0d]: got %b want %b", i, obs_gnt, want); end
      total++; if (obs_rvalid !== exp_rvalid) begin bad++; $display("[TB] FAIL contention_rvalid[%0d]: got %b want %b", i, obs_rvalid, exp_rvalid); end
      total++; if (obs_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL contention_rdata[%0d]: got %h want %h", i, obs_rdata, exp_rdata); end
    end
  endtask

  task automatic test_lock();
    logic [DW-1:0] wdat [4];
    apply_stimulus(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    apply_stimulus(1'b0, 2'b01, 2'b00, 2'b00, 10'h100, '0, '0, '0);
    total++; if (obs_gnt !== 2'b01) begin bad++; $display("[TB] FAIL lock_pre_gnt: got %b want 01", obs_gnt); end
    for (int i = 0; i < 4; i++) begin
      wdat[i] = DW'($urandom);
      apply_stimulus(1'b0, 2'b11, 2'b10, {(i < 3), 1'b0}, 10'h100, AW'(32'h20 + i), '0, wdat[i]);
      total++; if (obs_gnt !== 2'b10) begin bad++; $display("[TB] FAIL lock_gnt[%0d]: got %b want 10", i, obs_gnt); end
      total++; if (obs_ram_we !== 1'b1 || obs_ram_addr !== AW'(32'h20 + i)) begin
        bad++; $display("[TB] FAIL lock_ram[%0d]: got we=%b addr=%h want we=1 addr=%h", i, obs_ram_we, obs_ram_addr, 32'h20 + i);
      end
    end
    apply_stimulus(1'b0, 2'b01, 2'b00, 2'b00, 10'h100, '0, '0, '0);
    total++; if (obs_gnt !== 2'b01) begin bad++; $display("[TB] FAIL lock_release_gnt: got %b want 01", obs_gnt); end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 2'b01, 2'b00, 2'b00, AW'(32'h20 + i), '0, '0, '0);
      total++; if (obs_rvalid !== 2'b01 || obs_rdata !== wdat[i]) begin
        bad++; $display("[TB] FAIL lock_readback[%0d]: got v=%b d=%h want v=01 d=%h", i, obs_rvalid, obs_rdata, wdat[i]);
      end
    end
  endtask

  task automatic test_write_read();
    apply_stimulus(1'b0, 2'b10, 2'b10, 2'b00, 10'h000, 10'h3FF, '0, 32'h5A5A5A5A);
    total++; if (obs_gnt !== 2'b10 || obs_ram_we !== 1'b1) begin
      bad++; $display("[TB] FAIL wr_gnt: got gnt=%b we=%b want gnt=10 we=1", obs_gnt, obs_ram_we);
    end
    total++; if (obs_rvalid !== 2'b00) begin bad++; $display("[TB] FAIL wr_no_rvalid: got %b want 00", obs_rvalid); end
    apply_stimulus(1'b0, 2'b01, 2'b00, 2'b00, 10'h3FF, '0, '0, '0);
    total++; if (obs_rvalid !== 2'b01) begin bad++; $display("[TB] FAIL rd_rvalid: got %b want 01", obs_rvalid); end
    total++; if (obs_rdata !== 32'h5A5A5A5A) begin bad++; $display("[TB] FAIL rd_rdata: got %h want 5a5a5a5a", obs_rdata); end
  endtask

  task automatic test_reset_in_lock();
    apply_stimulus(1'b0, 2'b01, 2'b00, 2'b01, AW'($urandom_range(0, 1023)), '0, '0, '0);
    total++; if (obs_gnt !== 2'b01 || obs_rvalid !== 2'b01) begin
      bad++; $display("[TB] FAIL rlock_enter: got gnt=%b v=%b want gnt=01 v=01", obs_gnt, obs_rvalid);
    end
    rst     = 1'b1;
    bus.req = 2'b11;
    #1;
    total++; if (bus.rvalid !== 2'b00) begin bad++; $display("[TB] FAIL rlock_drop: got %b want 00", bus.rvalid); end
    apply_stimulus(1'b1, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
    total++; if (obs_gnt !== 2'b00 || obs_rvalid !== 2'b00) begin
      bad++; $display("[TB] FAIL rlock_reset: got gnt=%b v=%b want 00 00", obs_gnt, obs_rvalid);
    end
    apply_stimulus(1'b0, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
    total++; if (obs_gnt !== 2'b01) begin bad++; $display("[TB] FAIL rlock_rr: got %b want 01", obs_gnt); end
    apply_stimulus(1'b0, 2'b10, 2'b00, 2'b00, '0, '0, '0, '0);
    total++; if (obs_gnt !== 2'b10) begin bad++; $display("[TB] FAIL rlock_idle: got %b want 10", obs_gnt); end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] lk;
    apply_stimulus(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      lk = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      apply_stimulus(r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), lk,
                     AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                     DW'($urandom), DW'($urandom));
      total++; if (obs_gnt !== exp_gnt) begin bad++; $display("[TB] FAIL rand_gnt[%0d]: got %b want %b", i, obs_gnt, exp_gnt); end
      total++; if (obs_ram_we !== exp_ram_we) begin bad++; $display("[TB] FAIL rand_ram_we[%0d]: got %b want %b", i, obs_ram_we, exp_ram_we); end
      total++; if (obs_ram_addr !== exp_ram_addr) begin bad++; $display("[TB] FAIL rand_ram_addr[%0d]: got %h want %h", i, obs_ram_addr, exp_ram_addr); end
      if (exp_ram_we) begin
        total++; if (obs_ram_wrdata !== exp_ram_wrdata) begin bad++; $display("[TB] FAIL rand_wrdata[%0d]: got %h want %h", i, obs_ram_wrdata, exp_ram_wrdata); end
      end
      total++; if (obs_rvalid !== exp_rvalid) begin bad++; $display("[TB] FAIL rand_rvalid[%0d]: got %b want %b", i, obs_rvalid, exp_rvalid); end
      if (exp_rvalid != 2'b00) begin
        total++; if (obs_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", i, obs_rdata, exp_rdata); end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = 2'b00;
    bus.we      = 2'b00;
    bus.lock    = 2'b00;
    bus.addr0   = '0;
    bus.addr1   = '0;
    bus.wrdata0 = '0;
    bus.wrdata1 = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = DW'($urandom);
      shadow[i] = ram[i];
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_write_read();
    test_reset_in_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
